// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Holds the FSM state encoding, frame length arithmetic and the parity reduction.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // UART bit periods in one frame: start + data + optional parity + stop bits.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits);
        return 32'd1 + data_bits + parity_en + stop_bits;
    endfunction

    // Even parity of a word; callers zero-extend, which leaves the XOR unchanged.
    function automatic logic xor_reduce(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the async FIFO read side and its UART consumer.
// master = the consumer that issues pops; slave = the FIFO that answers them.
interface fifo_uart_tx_if #(
    parameter int DATA = 8
);
    import uart_tx_pkg::*;

    logic            empty;
    logic [DATA-1:0] rdata;
    logic            r_en;

    modport master (input empty, input rdata, output r_en);
    modport slave  (output empty, output rdata, input r_en);

endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while run=1, parked at 0 otherwise.
// tick marks the terminal count; tick_pre marks the cycle just before it.
module baud_tick_gen
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic rclk,
    input  logic rrst,
    input  logic run,
    output logic tick,
    output logic tick_pre
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap on terminal value, hold at zero when not running.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = run && (cnt_q == CNT_LAST);
    assign tick_pre = run && (cnt_q == CNT_PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains the read side of an async FIFO.
// Outputs are computed from the next state so every pin comes straight from a flop.
module fifo_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA         = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              tx_en,
    fifo_uart_tx_if.master    fifo,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);

    localparam int BIT_W = $clog2(DATA);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_SENSE = (PARITY_ODD != 0);

    tx_state_e       state_q, state_d;
    logic [DATA-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic            par_q, par_d;
    logic            txd_q, txd_d;
    logic            r_en_q, r_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick;
    logic            tick_pre;

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .rclk     (rclk),
        .rrst     (rrst),
        .run      (state_q != ST_IDLE),
        .tick     (tick),
        .tick_pre (tick_pre)
    );

    // Next-state, datapath and registered-output precomputation.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        par_d   = par_q;
        r_en_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_en && !fifo.empty) begin
                    state_d = ST_START;
                    shreg_d = fifo.rdata;
                    par_d   = xor_reduce(64'(fifo.rdata));
                    bit_d   = '0;
                    r_en_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Raised one cycle early so the flop shows it during the last stop cycle.
                done_d = tick_pre && (bit_q == STOP_LAST);
                if (tick) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                bit_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE:   txd_d = 1'b1;
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shreg_d[0];
            ST_PARITY: txd_d = par_d ^ PAR_SENSE;
            ST_STOP:   txd_d = 1'b1;
            default:   txd_d = 1'b1;
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            r_en_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            r_en_q  <= r_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo.r_en  = r_en_q;
    assign txd        = txd_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four parameter sets share one clock, each fed by a FIFO model.
// Written words go to a scoreboard queue; per-instance line decoders pop and compare.
module tb_fifo_uart_tx;
    import uart_tx_pkg::*;

    localparam int CPB = 4;

    typedef struct packed {
        logic [1:0] dut;
        logic [7:0] data;
    } exp_t;

    logic clk  = 1'b0;
    logic rrst = 1'b1;
    logic tx_en [4];
    logic txd_w [4];
    logic busy_w [4];
    logic fd_w [4];
    logic ren_w [4];
    logic empty_w [4];

    logic [7:0] fmem [4][16];
    int rp [4] = '{0, 0, 0, 0};
    int wp [4] = '{0, 0, 0, 0};
    int popc [4] = '{0, 0, 0, 0};
    int popt [4][16];
    int cyc = 0;

    exp_t exp_q [$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int PE  = (g == 1 || g == 2) ? 1 : 0;
        localparam int ODD = (g == 2) ? 1 : 0;
        localparam int SB  = (g == 3) ? 2 : 1;
        localparam int NB  = 1 + 8 + PE + SB;

        fifo_uart_tx_if #(.DATA(8)) bus ();

        assign bus.empty  = (rp[g] == wp[g]);
        assign bus.rdata  = fmem[g][rp[g] % 16];
        assign ren_w[g]   = bus.r_en;
        assign empty_w[g] = bus.empty;

        fifo_uart_tx #(
            .DATA(8), .CLKS_PER_BIT(CPB), .STOP_BITS(SB),
            .PARITY_EN(PE), .PARITY_ODD(ODD)
        ) dut (
            .rclk       (clk),
            .rrst       (rrst),
            .tx_en      (tx_en[g]),
            .fifo       (bus),
            .txd        (txd_w[g]),
            .busy       (busy_w[g]),
            .frame_done (fd_w[g])
        );

        // FIFO model: the word leaves at the end of the cycle that pops it.
        always @(negedge clk) begin
            if (ren_w[g] === 1'b1) begin
                popt[g][popc[g] % 16] = cyc;
                popc[g] = popc[g] + 1;
                rp[g] = rp[g] + 1;
            end
        end

        // Line decoder: samples every cycle of a frame and checks it against the scoreboard.
        initial begin : mon
            logic [15:0] bits;
            logic [7:0]  data;
            logic        abort, unstable, fd_bad, stop_ok;
            exp_t        e;
            forever begin
                @(negedge clk);
                if (txd_w[g] === 1'b0 && busy_w[g] === 1'b1) begin
                    abort = 1'b0; unstable = 1'b0; fd_bad = 1'b0; bits = '0;
                    for (int i = 0; i < NB * CPB; i++) begin
                        if (i > 0) @(negedge clk);
                        if (busy_w[g] !== 1'b1) begin
                            abort = 1'b1;
                            break;
                        end
                        if (i % CPB == 0) bits[i / CPB] = txd_w[g];
                        else if (txd_w[g] !== bits[i / CPB]) unstable = 1'b1;
                        if (fd_w[g] !== (i == NB * CPB - 1)) fd_bad = 1'b1;
                    end
                    if (!abort) begin
                        @(negedge clk);
                        check_eq("busy_after_frame", busy_w[g], 0);
                        check_eq("start_bit", bits[0], 0);
                        check_eq("bit_stable", unstable, 0);
                        check_eq("frame_done_pos", fd_bad, 0);
                        stop_ok = 1'b1;
                        for (int b = 9 + PE; b < NB; b++) if (bits[b] !== 1'b1) stop_ok = 1'b0;
                        check_eq("stop_bits", stop_ok, 1);
                        data = bits[8:1];
                        if (exp_q.size() == 0) begin
                            check_eq("frame_expected", 0, 1);
                        end else begin
                            e = exp_q.pop_front();
                            check_eq("frame_dut", g, e.dut);
                            check_eq("frame_data", data, e.data);
                            if (PE != 0) check_eq("parity_bit", bits[9], (^e.data) ^ (ODD != 0));
                        end
                    end
                end
            end
        end
    end

    task automatic push_word(input int k, input logic [7:0] d);
        exp_t e;
        fmem[k][wp[k] % 16] = d;
        wp[k] = wp[k] + 1;
        e.dut = 2'(k);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n = 0;
        repeat (2) @(negedge clk);
        while ((busy_w[k] !== 1'b0 || rp[k] != wp[k]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        if (n >= budget) check_eq("drain_timeout", n, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int base, pc, n;
        logic hi_ok;
        for (int k = 0; k < 4; k++) tx_en[k] = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check_eq("rst_txd", txd_w[k], 1);
            check_eq("rst_busy", busy_w[k], 0);
            check_eq("rst_ren", ren_w[k], 0);
            check_eq("rst_frame_done", fd_w[k], 0);
        end
        rrst = 1'b0;
        @(negedge clk);

        // Basic 8N1 frame, r_en one cycle after empty falls.
        tx_en[0] = 1'b1;
        base = popc[0];
        pc = cyc;
        push_word(0, 8'hA5);
        wait_idle(0, 200);
        check_eq("basic_pops", popc[0] - base, 1);
        check_eq("basic_ren_latency", popt[0][base % 16] - pc, 1);

        // Even and odd parity.
        tx_en[1] = 1'b1;
        push_word(1, 8'hA5);
        wait_idle(1, 200);
        tx_en[2] = 1'b1;
        push_word(2, 8'hA5);
        wait_idle(2, 200);

        // Two stop bits, back-to-back spacing includes one IDLE cycle.
        tx_en[3] = 1'b1;
        base = popc[3];
        push_word(3, 8'h3C);
        push_word(3, 8'h81);
        wait_idle(3, 300);
        check_eq("sb2_pops", popc[3] - base, 2);
        check_eq("sb2_spacing", popt[3][(base + 1) % 16] - popt[3][base % 16],
                 frame_bits(8, 0, 2) * CPB + 1);

        // Back-to-back on 8N1.
        base = popc[0];
        push_word(0, 8'h01);
        push_word(0, 8'hFF);
        push_word(0, 8'h00);
        wait_idle(0, 400);
        check_eq("b2b_pops", popc[0] - base, 3);
        check_eq("b2b_gap1", popt[0][(base + 1) % 16] - popt[0][base % 16], 41);
        check_eq("b2b_gap2", popt[0][(base + 2) % 16] - popt[0][(base + 1) % 16], 41);
        check_eq("b2b_empty", empty_w[0], 1);
        repeat (20) @(negedge clk);
        check_eq("b2b_no_fourth_pop", popc[0] - base, 3);

        // tx_en gating with a non-empty FIFO.
        tx_en[0] = 1'b0;
        base = popc[0];
        push_word(0, 8'h5A);
        hi_ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (txd_w[0] !== 1'b1) hi_ok = 1'b0;
        end
        check_eq("gate_txd_high", hi_ok, 1);
        check_eq("gate_no_pop", popc[0] - base, 0);

        // Deassert mid-frame: frame completes, no next pop.
        tx_en[0] = 1'b1;
        repeat (10) @(negedge clk);
        push_word(0, 8'h96);
        tx_en[0] = 1'b0;
        n = 0;
        while (busy_w[0] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("gate_busy_timeout", n, 0);
        repeat (60) @(negedge clk);
        check_eq("gate_midframe_pops", popc[0] - base, 1);
        tx_en[0] = 1'b1;
        wait_idle(0, 200);
        check_eq("gate_resume_pops", popc[0] - base, 2);

        // Reset during DATA bit 3; the popped word is lost.
        base = popc[0];
        push_word(0, 8'hC3);
        push_word(0, 8'h3A);
        repeat (18) @(negedge clk);
        rrst = 1'b1;
        @(negedge clk);
        check_eq("midrst_txd", txd_w[0], 1);
        check_eq("midrst_busy", busy_w[0], 0);
        check_eq("midrst_ren", ren_w[0], 0);
        check_eq("midrst_pops", popc[0] - base, 1);
        rrst = 1'b0;
        void'(exp_q.pop_front());
        wait_idle(0, 200);
        check_eq("midrst_after_pops", popc[0] - base, 2);

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
